// File: rtl/wreg_dest_queue_if.sv
// wreg_dest_queue_if: groups the destination-queue signals between a producer
// (master) and the queue itself (slave).
//   sel/rd_field/rt_field   destination select and instruction fields
//   push/pop/clear          enqueue, dequeue and synchronous flush
//   lookup_a/lookup_b       source registers checked against pending writes
//   dest_out/dest_valid     head of queue (show-ahead)
//   sel_addr                combinational mux result
//   full/empty/count        occupancy
//   hit_a/hit_b             hazard lookup results
//   overflow/underflow      sticky error flags
interface wreg_dest_queue_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [1:0]        sel;
    logic [ADDR_W-1:0] rd_field;
    logic [ADDR_W-1:0] rt_field;
    logic              push;
    logic              pop;
    logic              clear;
    logic [ADDR_W-1:0] lookup_a;
    logic [ADDR_W-1:0] lookup_b;
    logic [ADDR_W-1:0] dest_out;
    logic              dest_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              hit_a;
    logic              hit_b;
    logic              overflow;
    logic              underflow;

    modport master (
        output sel, rd_field, rt_field, push, pop, clear, lookup_a, lookup_b,
        input  dest_out, dest_valid, sel_addr, full, empty, count, hit_a, hit_b,
               overflow, underflow
    );

    modport slave (
        input  sel, rd_field, rt_field, push, pop, clear, lookup_a, lookup_b,
        output dest_out, dest_valid, sel_addr, full, empty, count, hit_a, hit_b,
               overflow, underflow
    );
endinterface

// File: rtl/wreg_dest_queue.sv
// wreg_dest_queue: selects the register-file write address (rd, rt, link reg,
// stack pointer) and queues it in a DEPTH-entry show-ahead FIFO of pending
// writebacks, with two combinational hazard-lookup ports.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   q      wreg_dest_queue_if.slave bundle (see interface header)
module wreg_dest_queue #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RA_REG = 31,
    parameter int unsigned SP_REG = 29
) (
    input logic              clk,
    input logic              reset,
    wreg_dest_queue_if.slave q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;

    logic [ADDR_W-1:0] sel_addr;
    logic              is_full;
    logic              is_empty;
    logic              do_push;
    logic              do_pop;
    logic              hit_a;
    logic              hit_b;

    always_comb begin
        sel_addr = '0;
        case (q.sel)
            2'b00:   sel_addr = q.rd_field;
            2'b01:   sel_addr = q.rt_field;
            2'b10:   sel_addr = ADDR_W'(RA_REG);
            default: sel_addr = ADDR_W'(SP_REG);
        endcase
    end

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // A pop on a full queue frees the slot the push lands in, so both go.
    // A pop on an empty queue never consumes a same-cycle push (no bypass).
    assign do_pop  = q.pop && !is_empty;
    assign do_push = q.push && (!is_full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (q.clear) begin
            // Flush wins over push/pop; sticky flags survive it.
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            // Placed after the pop so a full-queue push+pop on the same slot keeps it valid.
            if (do_push) begin
                entry_q[wr_ptr_q] <= sel_addr;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
            if (q.push && !do_push) overflow_q <= 1'b1;
            if (q.pop && is_empty) underflow_q <= 1'b1;
        end
    end

    // Register 0 is hardwired, so it can never be a hazard.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && entry_q[i] == q.lookup_a && q.lookup_a != '0) hit_a = 1'b1;
            if (valid_q[i] && entry_q[i] == q.lookup_b && q.lookup_b != '0) hit_b = 1'b1;
        end
    end

    assign q.sel_addr   = sel_addr;
    assign q.dest_out   = is_empty ? '0 : entry_q[rd_ptr_q];
    assign q.dest_valid = !is_empty;
    assign q.full       = is_full;
    assign q.empty      = is_empty;
    assign q.count      = count_q;
    assign q.hit_a      = hit_a;
    assign q.hit_b      = hit_b;
    assign q.overflow   = overflow_q;
    assign q.underflow  = underflow_q;
endmodule

// File: tb/tb_wreg_dest_queue.sv
module tb_wreg_dest_queue;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    wreg_dest_queue_if #(.ADDR_W(5), .DEPTH(4)) bus ();

    wreg_dest_queue #(.ADDR_W(5), .DEPTH(4), .RA_REG(31), .SP_REG(29)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.sel      = 2'b00;
        bus.rd_field = '0;
        bus.rt_field = '0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.clear    = 1'b0;
        bus.lookup_a = '0;
        bus.lookup_b = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        step();
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.dest_out !== 5'd0) begin n_bad++; $display("FAIL reset_dest_out: got %0d want 0", bus.dest_out); end
        // Set underflow, fill three entries, then reset between edges.
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL pre_reset_underflow: got %b want 1", bus.underflow); end
        bus.rd_field = 5'd7;
        bus.push     = 1'b1;
        repeat (3) step();
        bus.push     = 1'b0;
        bus.lookup_a = 5'd7;
        #1;
        n_cmp++; if (bus.hit_a !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hit: got %b want 1", bus.hit_a); end
        n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL pre_reset_count: got %0d want 3", bus.count); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL midreset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL midreset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.dest_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", bus.dest_valid); end
        n_cmp++; if (bus.hit_a !== 1'b0) begin n_bad++; $display("FAIL midreset_hit: got %b want 0", bus.hit_a); end
        n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL midreset_underflow: got %b want 0", bus.underflow); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL midreset_overflow: got %b want 0", bus.overflow); end
        #1;
        reset = 1'b0;
        idle();
        step();
    endtask

    task automatic test_select();
        logic [4:0] exp_sel [4];
        exp_sel[0] = 5'd8; exp_sel[1] = 5'd9; exp_sel[2] = 5'd31; exp_sel[3] = 5'd29;
        pulse_reset();
        bus.rd_field = 5'd8;
        bus.rt_field = 5'd9;
        for (int s = 0; s < 4; s++) begin
            bus.sel  = 2'(s);
            bus.push = 1'b1;
            #1;
            n_cmp++; if (bus.sel_addr !== exp_sel[s]) begin n_bad++; $display("FAIL sel_addr[%0d]: got %0d want %0d", s, bus.sel_addr, exp_sel[s]); end
            step();
        end
        bus.push = 1'b0;
        n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL sel_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL sel_full: got %b want 1", bus.full); end
        for (int s = 0; s < 4; s++) begin
            n_cmp++; if (bus.dest_out !== exp_sel[s]) begin n_bad++; $display("FAIL sel_pop[%0d]: got %0d want %0d", s, bus.dest_out, exp_sel[s]); end
            bus.pop = 1'b1;
            step();
        end
        bus.pop = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL sel_drained: got %b want 1", bus.empty); end
        n_cmp++; if (bus.dest_out !== 5'd0) begin n_bad++; $display("FAIL sel_empty_dest: got %0d want 0", bus.dest_out); end
        idle();
    endtask

    task automatic test_full();
        logic [4:0] exp_q [4];
        exp_q[0] = 5'd2; exp_q[1] = 5'd3; exp_q[2] = 5'd4; exp_q[3] = 5'd7;
        pulse_reset();
        bus.sel  = 2'b00;
        bus.push = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.rd_field = 5'(i);
            step();
        end
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", bus.full); end
        // push+pop on full: both accepted, no overflow
        bus.rd_field = 5'd7;
        bus.pop      = 1'b1;
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_pushpop_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL full_pushpop_overflow: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.dest_out !== 5'd2) begin n_bad++; $display("FAIL full_pushpop_head: got %0d want 2", bus.dest_out); end
        // push alone on full: dropped
        bus.rd_field = 5'd5;
        step();
        bus.push = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_flag: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL overflow_count: got %0d want 4", bus.count); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.dest_out !== exp_q[i]) begin n_bad++; $display("FAIL full_drain[%0d]: got %0d want %0d", i, bus.dest_out, exp_q[i]); end
            bus.pop = 1'b1;
            step();
        end
        bus.pop = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL full_drained: got %b want 1", bus.empty); end
        idle();
    endtask

    task automatic test_wrap();
        pulse_reset();
        bus.sel = 2'b01;
        for (int i = 0; i < 10; i++) begin
            bus.rt_field = 5'(10 + i);
            bus.push     = 1'b1;
            step();
            bus.push = 1'b0;
            n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, bus.count); end
            n_cmp++; if (bus.dest_out !== 5'(10 + i)) begin n_bad++; $display("FAIL wrap_head[%0d]: got %0d want %0d", i, bus.dest_out, 10 + i); end
            bus.pop = 1'b1;
            step();
            bus.pop = 1'b0;
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.underflow !== 1'b0) begin n_bad++; $display("FAIL wrap_underflow: got %b want 0", bus.underflow); end
        idle();
    endtask

    task automatic test_hazard();
        pulse_reset();
        bus.lookup_a = 5'd31;
        bus.lookup_b = 5'd0;
        bus.push     = 1'b1;
        bus.sel      = 2'b00;
        bus.rd_field = 5'd8;
        step();
        bus.rd_field = 5'd0;
        step();
        bus.sel = 2'b10;
        #1;
        // 31 is being pushed this cycle but is not yet visible
        n_cmp++; if (bus.hit_a !== 1'b0) begin n_bad++; $display("FAIL hazard_no_fwd: got %b want 0", bus.hit_a); end
        step();
        bus.push = 1'b0;
        n_cmp++; if (bus.hit_a !== 1'b1) begin n_bad++; $display("FAIL hazard_hit_a: got %b want 1", bus.hit_a); end
        n_cmp++; if (bus.hit_b !== 1'b0) begin n_bad++; $display("FAIL hazard_reg0: got %b want 0", bus.hit_b); end
        bus.lookup_b = 5'd8;
        #1;
        n_cmp++; if (bus.hit_b !== 1'b1) begin n_bad++; $display("FAIL hazard_hit_b8: got %b want 1", bus.hit_b); end
        n_cmp++; if (bus.dest_out !== 5'd8) begin n_bad++; $display("FAIL hazard_head0: got %0d want 8", bus.dest_out); end
        bus.pop = 1'b1;
        step();
        n_cmp++; if (bus.hit_b !== 1'b0) begin n_bad++; $display("FAIL hazard_b_gone: got %b want 0", bus.hit_b); end
        n_cmp++; if (bus.dest_out !== 5'd0) begin n_bad++; $display("FAIL hazard_head1: got %0d want 0", bus.dest_out); end
        n_cmp++; if (bus.dest_valid !== 1'b1) begin n_bad++; $display("FAIL hazard_valid1: got %b want 1", bus.dest_valid); end
        step();
        n_cmp++; if (bus.hit_a !== 1'b1) begin n_bad++; $display("FAIL hazard_still: got %b want 1", bus.hit_a); end
        n_cmp++; if (bus.dest_out !== 5'd31) begin n_bad++; $display("FAIL hazard_head2: got %0d want 31", bus.dest_out); end
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.hit_a !== 1'b0) begin n_bad++; $display("FAIL hazard_drop: got %b want 0", bus.hit_a); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL hazard_empty: got %b want 1", bus.empty); end
        idle();
    endtask

    task automatic test_empty_pop_clear();
        // simultaneous push+pop on empty: push only
        pulse_reset();
        bus.rd_field = 5'd12;
        bus.push     = 1'b1;
        bus.pop      = 1'b1;
        step();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL emptypp_count: got %0d want 1", bus.count); end
        n_cmp++; if (bus.dest_out !== 5'd12) begin n_bad++; $display("FAIL emptypp_head: got %0d want 12", bus.dest_out); end
        n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL emptypp_underflow: got %b want 1", bus.underflow); end
        // pop alone on empty
        pulse_reset();
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_flag: got %b want 1", bus.underflow); end
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL underflow_count: got %0d want 0", bus.count); end
        bus.rd_field = 5'd14;
        bus.push     = 1'b1;
        step();
        n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL preclear_count: got %0d want 1", bus.count); end
        // clear beats a simultaneous push
        bus.rd_field = 5'd13;
        bus.clear    = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL clear_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.dest_valid !== 1'b0) begin n_bad++; $display("FAIL clear_valid: got %b want 0", bus.dest_valid); end
        n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL clear_sticky: got %b want 1", bus.underflow); end
        bus.lookup_a = 5'd14;
        #1;
        n_cmp++; if (bus.hit_a !== 1'b0) begin n_bad++; $display("FAIL clear_hit: got %b want 0", bus.hit_a); end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        idle();
        test_reset();
        test_select();
        test_full();
        test_wrap();
        test_hazard();
        test_empty_pop_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
